// File: rtl/eth_sf_port.sv
// eth_sf_port: store-and-forward Ethernet port buffer.
// Frames are written into a circular word buffer and become visible for transmit
// only once their EOP is accepted intact. Overflowing or malformed frames are dropped
// whole. An optional DA/SA swap is applied on the way out.
module eth_sf_port #(
    parameter int DEPTH      = 16,
    parameter int MAX_FRAMES = 4,
    parameter int CNT_W      = 16
) (
    input  logic                   clk,
    input  logic                   resetN,
    input  logic                   in_vld,
    input  logic                   in_sop,
    input  logic                   in_eop,
    input  logic [63:0]            in_data,
    input  logic                   swap_en,
    output logic                   out_vld,
    input  logic                   out_rdy,
    output logic                   out_sop,
    output logic                   out_eop,
    output logic [63:0]            out_data,
    output logic [CNT_W-1:0]       frames_fwd,
    output logic [CNT_W-1:0]       frames_drop,
    output logic [$clog2(DEPTH):0] buf_level
);

    localparam int AW = $clog2(DEPTH);
    localparam int QW = (MAX_FRAMES > 1) ? $clog2(MAX_FRAMES) : 1;
    localparam int CW = $clog2(MAX_FRAMES + 1);

    typedef enum logic {W_IDLE, W_FRAME} wState_t;
    typedef enum logic {R_IDLE, R_FRAME} rState_t;

    logic [63:0]   mem [DEPTH];
    logic [AW:0]   qStart [MAX_FRAMES];
    logic [AW:0]   qLen   [MAX_FRAMES];

    wState_t       wState_q, wState_d;
    rState_t       rState_q, rState_d;
    logic [AW:0]   wrPtr_q, wrPtr_d, frmStart_q, frmStart_d, frmLen_q, frmLen_d;
    logic          discard_q, discard_d;
    logic [AW:0]   freePtr_q, freePtr_d, rdPtr_q, rdPtr_d, rdRem_q, rdRem_d, curLen_q, curLen_d;
    logic          swap_q, swap_d, word1Next_q, word1Next_d;
    logic [31:0]   daLo_q, daLo_d;
    logic          outVld_q, outVld_d, outSop_q, outSop_d, outEop_q, outEop_d;
    logic [63:0]   outData_q, outData_d;
    logic [QW-1:0] qHead_q, qTail_q;
    logic [CW-1:0] qCount_q;
    logic [CNT_W-1:0] fwd_q, fwd_d, drop_q, drop_d;

    logic          memWe, push, pop, eopXfer, advance, curFull, baseFull;
    logic [AW-1:0] memWaddr, hdAddr1;
    logic [AW:0]   base, curLevel, baseLevel, hdStart;
    logic [1:0]    dropInc;
    logic [CNT_W:0] dropSum;
    logic [63:0]   rdWord, w0;

    assign curLevel  = wrPtr_q - freePtr_q;
    assign curFull   = (curLevel == (AW+1)'(DEPTH));
    assign base      = (wState_q == W_FRAME) ? frmStart_q : wrPtr_q;
    assign baseLevel = base - freePtr_q;
    assign baseFull  = (baseLevel == (AW+1)'(DEPTH));

    // Write side: start, extend, commit, abort or discard frames as words arrive.
    always_comb begin
        wState_d   = wState_q;
        wrPtr_d    = wrPtr_q;
        frmStart_d = frmStart_q;
        frmLen_d   = frmLen_q;
        discard_d  = discard_q;
        memWe      = 1'b0;
        memWaddr   = wrPtr_q[AW-1:0];
        push       = 1'b0;
        dropInc    = 2'd0;
        if (in_vld && in_sop) begin
            if (wState_q == W_FRAME && !discard_q) dropInc = dropInc + 2'd1;
            wrPtr_d    = base;
            frmStart_d = base;
            discard_d  = 1'b0;
            if (in_eop) begin
                dropInc  = dropInc + 2'd1;
                wState_d = W_IDLE;
            end else if (baseFull) begin
                dropInc   = dropInc + 2'd1;
                discard_d = 1'b1;
                wState_d  = W_FRAME;
            end else begin
                memWe    = 1'b1;
                memWaddr = base[AW-1:0];
                wrPtr_d  = base + (AW+1)'(1);
                frmLen_d = (AW+1)'(1);
                wState_d = W_FRAME;
            end
        end else if (in_vld && wState_q == W_FRAME) begin
            if (discard_q) begin
                if (in_eop) begin
                    wState_d  = W_IDLE;
                    discard_d = 1'b0;
                end
            end else if (curFull || (in_eop && qCount_q == CW'(MAX_FRAMES))) begin
                dropInc = dropInc + 2'd1;
                wrPtr_d = frmStart_q;
                if (in_eop) wState_d = W_IDLE;
                else        discard_d = 1'b1;
            end else begin
                memWe    = 1'b1;
                wrPtr_d  = wrPtr_q + (AW+1)'(1);
                frmLen_d = frmLen_q + (AW+1)'(1);
                if (in_eop) begin
                    push     = 1'b1;
                    wState_d = W_IDLE;
                end
            end
        end
    end

    assign eopXfer = outVld_q && out_rdy && outEop_q;
    assign advance = !outVld_q || out_rdy;
    assign rdWord  = mem[rdPtr_q[AW-1:0]];
    assign hdStart = qStart[qHead_q];
    assign hdAddr1 = hdStart[AW-1:0] + AW'(1);
    assign w0      = mem[hdStart[AW-1:0]];

    // Read side: refill the output register whenever it is empty or being accepted.
    always_comb begin
        rState_d    = rState_q;
        rdPtr_d     = rdPtr_q;
        rdRem_d     = rdRem_q;
        curLen_d    = curLen_q;
        swap_d      = swap_q;
        daLo_d      = daLo_q;
        word1Next_d = word1Next_q;
        outVld_d    = outVld_q;
        outSop_d    = outSop_q;
        outEop_d    = outEop_q;
        outData_d   = outData_q;
        freePtr_d   = eopXfer ? freePtr_q + curLen_q : freePtr_q;
        pop         = 1'b0;
        if (advance) begin
            if (rState_q == R_FRAME && rdRem_q != '0) begin
                outVld_d    = 1'b1;
                outSop_d    = 1'b0;
                outEop_d    = (rdRem_q == (AW+1)'(1));
                outData_d   = (word1Next_q && swap_q) ? {daLo_q, rdWord[31:0]} : rdWord;
                word1Next_d = 1'b0;
                rdPtr_d     = rdPtr_q + (AW+1)'(1);
                rdRem_d     = rdRem_q - (AW+1)'(1);
            end else if (qCount_q != '0) begin
                pop         = 1'b1;
                rState_d    = R_FRAME;
                outVld_d    = 1'b1;
                outSop_d    = 1'b1;
                outEop_d    = 1'b0;
                swap_d      = swap_en;
                outData_d   = swap_en ? {w0[15:0], mem[hdAddr1][63:32], w0[63:48]} : w0;
                daLo_d      = w0[47:16];
                word1Next_d = 1'b1;
                rdPtr_d     = hdStart + (AW+1)'(1);
                rdRem_d     = qLen[qHead_q] - (AW+1)'(1);
                curLen_d    = qLen[qHead_q];
            end else begin
                outVld_d = 1'b0;
                outSop_d = 1'b0;
                outEop_d = 1'b0;
                rState_d = R_IDLE;
            end
        end
    end

    // Statistics: saturating forward and drop counts.
    always_comb begin
        fwd_d   = (eopXfer && fwd_q != '1) ? fwd_q + CNT_W'(1) : fwd_q;
        dropSum = {1'b0, drop_q} + (CNT_W+1)'(dropInc);
        drop_d  = dropSum[CNT_W] ? '1 : dropSum[CNT_W-1:0];
    end

    // Buffer and frame-queue storage; contents are meaningless until pointers say otherwise.
    always_ff @(posedge clk) begin
        if (memWe) mem[memWaddr] <= in_data;
        if (push) begin
            qStart[qTail_q] <= frmStart_q;
            qLen[qTail_q]   <= frmLen_q + (AW+1)'(1);
        end
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!resetN) begin
            wState_q <= W_IDLE;      rState_q <= R_IDLE;
            wrPtr_q <= '0;           frmStart_q <= '0;       frmLen_q <= '0;
            discard_q <= 1'b0;       freePtr_q <= '0;        rdPtr_q <= '0;
            rdRem_q <= '0;           curLen_q <= '0;         swap_q <= 1'b0;
            daLo_q <= '0;            word1Next_q <= 1'b0;    outVld_q <= 1'b0;
            outSop_q <= 1'b0;        outEop_q <= 1'b0;       outData_q <= '0;
            qHead_q <= '0;           qTail_q <= '0;          qCount_q <= '0;
            fwd_q <= '0;             drop_q <= '0;
        end else begin
            wState_q <= wState_d;    rState_q <= rState_d;
            wrPtr_q <= wrPtr_d;      frmStart_q <= frmStart_d; frmLen_q <= frmLen_d;
            discard_q <= discard_d;  freePtr_q <= freePtr_d; rdPtr_q <= rdPtr_d;
            rdRem_q <= rdRem_d;      curLen_q <= curLen_d;   swap_q <= swap_d;
            daLo_q <= daLo_d;        word1Next_q <= word1Next_d; outVld_q <= outVld_d;
            outSop_q <= outSop_d;    outEop_q <= outEop_d;   outData_q <= outData_d;
            fwd_q <= fwd_d;          drop_q <= drop_d;
            if (push) qTail_q <= (qTail_q == QW'(MAX_FRAMES - 1)) ? '0 : qTail_q + QW'(1);
            if (pop)  qHead_q <= (qHead_q == QW'(MAX_FRAMES - 1)) ? '0 : qHead_q + QW'(1);
            qCount_q <= qCount_q + CW'(push) - CW'(pop);
        end
    end

    assign out_vld     = outVld_q;
    assign out_sop     = outSop_q;
    assign out_eop     = outEop_q;
    assign out_data    = outData_q;
    assign frames_fwd  = fwd_q;
    assign frames_drop = drop_q;
    assign buf_level   = curLevel;

endmodule

// File: tb/tb_eth_sf_port.sv
// Testbench for eth_sf_port: directed scenarios plus randomized frames checked
// against a frame-level scoreboard of expected output words and counters.
module tb_eth_sf_port;

    logic        clk;
    logic        resetN;
    logic        in_vld, in_sop, in_eop, swap_en, out_rdy;
    logic [63:0] in_data;
    logic        out_vld, out_sop, out_eop;
    logic [63:0] out_data;
    logic [15:0] frames_fwd, frames_drop;
    logic [4:0]  buf_level;

    int          checks = 0;
    int          failures = 0;
    int          expFwd = 0;
    int          expDrop = 0;
    logic [65:0] expQ [$];
    bit          monEn = 0;
    bit          prevStall = 0;
    logic [65:0] prevWord;
    int          rdyMode = 0;
    bit          rdyConst = 1;

    eth_sf_port #(.DEPTH(16), .MAX_FRAMES(4), .CNT_W(16)) dut (
        .clk(clk), .resetN(resetN),
        .in_vld(in_vld), .in_sop(in_sop), .in_eop(in_eop), .in_data(in_data),
        .swap_en(swap_en),
        .out_vld(out_vld), .out_rdy(out_rdy), .out_sop(out_sop), .out_eop(out_eop),
        .out_data(out_data),
        .frames_fwd(frames_fwd), .frames_drop(frames_drop), .buf_level(buf_level)
    );

    // Free-running clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Safety net so the run can never hang.
    initial begin
        #1000000;
        $display("[TB] FAIL globalTimeout observed=running expected=finished");
        $fatal(1, "[TB] global timeout");
    end

    task automatic checkOutput(input string tag, input logic [79:0] obs, input logic [79:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drive one input cycle and return just after the accepting edge.
    task automatic applyStimulus(input logic vld, input logic sop, input logic eop, input logic [63:0] data);
        in_vld = vld; in_sop = sop; in_eop = eop; in_data = data;
        @(posedge clk); #1;
        in_vld = 1'b0; in_sop = 1'b0; in_eop = 1'b0;
    endtask

    // Send a frame; if it should survive, record its expected output words (swap applied).
    task automatic sendFrame(input int len, input bit good, input bit fixedHdr, input int gapPct);
        logic [63:0] w [$];
        logic [47:0] da, sa;
        logic [63:0] e;
        for (int i = 0; i < len; i++) w.push_back({$urandom, $urandom});
        if (fixedHdr) begin
            w[0] = {48'h0A0B0C0D0E0F, 16'h1122};
            e    = w[1];
            w[1] = {32'h33445566, e[31:0]};
        end
        if (good) begin
            expFwd++;
            e  = w[0];
            da = e[63:16];
            e  = w[1];
            sa = {w[0][15:0], e[63:32]};
            for (int i = 0; i < len; i++) begin
                e = w[i];
                if (swap_en && i == 0) e = {sa, da[47:32]};
                if (swap_en && i == 1) e = {da[31:0], e[31:0]};
                expQ.push_back({(i == 0), (i == len - 1), e});
            end
        end
        for (int i = 0; i < len; i++) begin
            if (i > 0) while ($urandom_range(99) < gapPct) applyStimulus(0, 0, 0, '0);
            applyStimulus(1, (i == 0), (i == len - 1), w[i]);
        end
    endtask

    task automatic sendPartial(input int n);
        for (int i = 0; i < n; i++) applyStimulus(1, (i == 0), 0, {$urandom, $urandom});
        expDrop++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) applyStimulus(0, 0, 0, '0);
    endtask

    task automatic waitDrain();
        for (int i = 0; i < 3000 && expQ.size() != 0; i++) @(posedge clk);
        checkOutput("drain", expQ.size(), 0);
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic checkResetState(input string tag);
        checkOutput({tag, "_vld"}, {out_vld, out_sop, out_eop}, 0);
        checkOutput({tag, "_data"}, out_data, 0);
        checkOutput({tag, "_fwd"}, frames_fwd, 0);
        checkOutput({tag, "_drop"}, frames_drop, 0);
        checkOutput({tag, "_level"}, buf_level, 0);
    endtask

    // Downstream ready pattern: constant, alternating or random.
    initial begin
        out_rdy = 1'b1;
        forever begin
            @(posedge clk); #1;
            case (rdyMode)
                0:       out_rdy = rdyConst;
                1:       out_rdy = ~out_rdy;
                default: out_rdy = ($urandom_range(3) != 0);
            endcase
        end
    end

    // Output monitor: every accepted word must match the scoreboard; stalled words must hold.
    initial begin
        forever begin
            @(negedge clk);
            if (!monEn) prevStall = 0;
            else begin
                if (prevStall)
                    checkOutput("stallHold", {out_vld, out_sop, out_eop, out_data}, {1'b1, prevWord});
                if (out_vld && out_rdy) begin
                    checkOutput("wordExpected", (expQ.size() != 0), 1);
                    if (expQ.size() != 0) checkOutput("outWord", {out_sop, out_eop, out_data}, expQ.pop_front());
                end
                prevStall = out_vld && !out_rdy;
                prevWord  = {out_sop, out_eop, out_data};
            end
        end
    end

    initial begin
        resetN = 1'b0; in_vld = 0; in_sop = 0; in_eop = 0; in_data = '0; swap_en = 0;
        repeat (3) @(posedge clk);
        #1;
        checkResetState("reset");
        resetN = 1'b1;
        monEn  = 1;

        $display("[TB] single frame, no swap");
        sendFrame(4, 1, 1, 0);
        checkOutput("latencyBefore", out_vld, 0);
        @(posedge clk); #1;
        checkOutput("latencyAfter", out_vld, 1);
        waitDrain();
        checkOutput("fwdT1", frames_fwd, expFwd);

        $display("[TB] single frame, swap");
        swap_en = 1;
        sendFrame(4, 1, 1, 0);
        waitDrain();
        swap_en = 0;

        $display("[TB] overflow drop");
        rdyConst = 0;
        idle(1);
        sendFrame(10, 1, 0, 0);
        sendFrame(10, 0, 0, 0);
        expDrop++;
        idle(2);
        checkOutput("dropT3", frames_drop, expDrop);
        checkOutput("levelT3", buf_level, 10);
        rdyConst = 1;
        waitDrain();
        checkOutput("fwdT3", frames_fwd, expFwd);

        $display("[TB] SOP mid-frame abort");
        sendPartial(3);
        sendFrame(3, 1, 0, 0);
        waitDrain();
        checkOutput("dropT4", frames_drop, expDrop);
        checkOutput("fwdT4", frames_fwd, expFwd);

        $display("[TB] back-to-back 2-word frames with toggling ready");
        rdyMode = 1;
        for (int i = 0; i < 40; i++) begin
            sendFrame(2, 1, 0, 0);
            idle(4);
        end
        waitDrain();
        checkOutput("fwdT5", frames_fwd, expFwd);
        checkOutput("levelT5", buf_level, 0);

        $display("[TB] randomized frames");
        rdyMode = 2;
        for (int r = 0; r < 40; r++) begin
            waitDrain();
            swap_en = 1'($urandom_range(1));
            for (int k = 0; k < 2; k++) begin
                case ($urandom_range(9))
                    6: begin applyStimulus(1, 1, 1, {$urandom, $urandom}); expDrop++; end
                    7: begin sendPartial($urandom_range(1, 3)); sendFrame($urandom_range(2, 4), 1, 0, 20); end
                    8: applyStimulus(1, 0, 1'($urandom_range(1)), {$urandom, $urandom});
                    9: idle($urandom_range(1, 3));
                    default: sendFrame($urandom_range(2, 5), 1, 0, 20);
                endcase
            end
        end
        waitDrain();
        checkOutput("fwdRandom", frames_fwd, expFwd);
        checkOutput("dropRandom", frames_drop, expDrop);
        checkOutput("levelRandom", buf_level, 0);

        $display("[TB] reset mid-output");
        rdyMode = 0; rdyConst = 1; swap_en = 0;
        sendFrame(6, 1, 0, 0);
        for (int i = 0; i < 20 && !out_vld; i++) begin @(posedge clk); #1; end
        checkOutput("vldBeforeReset", out_vld, 1);
        @(posedge clk); #1;
        monEn  = 0;
        resetN = 1'b0;
        @(posedge clk); #1;
        resetN = 1'b1;
        expQ.delete();
        expFwd = 0;
        expDrop = 0;
        checkResetState("midReset");
        monEn = 1;
        sendFrame(3, 1, 0, 0);
        waitDrain();
        checkOutput("fwdAfterReset", frames_fwd, expFwd);
        checkOutput("dropAfterReset", frames_drop, expDrop);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/eth_sf_port.md
Name: eth_sf_port

Overview:
Parametrised store-and-forward Ethernet port buffer and the successor to the current receive/FIFO/send switch path. It accepts 64-bit frame words with SOP/EOP framing into a circular word buffer. A frame becomes visible for transmit only after its EOP is accepted intact. Frames that overflow the buffer or are malformed are dropped whole. Optional DA/SA MAC swap is applied on transmit, and the output uses a valid/ready handshake with statistics counters.

Parameters:
DEPTH, 16, buffer depth in 64-bit words, power of two, min 4
MAX_FRAMES, 4, max committed frames held simultaneously, min 1
CNT_W, 16, width of statistics counters

Ports:
clk  in  1  clock, all logic on rising edge
resetN  in  1  reset, synchronous, active-low
in_vld  in  1  input word valid; no input backpressure
in_sop  in  1  first word of frame, qualified by in_vld
in_eop  in  1  last word of frame, qualified by in_vld
in_data  in  64  frame word
swap_en  in  1  1 = swap DA/SA on transmit; sampled at the output frame's first word
out_vld  out  1  output word valid
out_rdy  in  1  downstream ready
out_sop  out  1  first output word
out_eop  out  1  last output word
out_data  out  64  output word
frames_fwd  out  CNT_W  frames fully transmitted, saturating
frames_drop  out  CNT_W  frames discarded, saturating
buf_level  out  log2(DEPTH)+1  words occupied, committed plus in-progress

Behaviour:
- Reset is synchronous, active-low on resetN at the rising edge of clk.
  - On reset: out_vld=0, out_sop=0, out_eop=0, out_data=0, frames_fwd=0, frames_drop=0, buf_level=0.
  - Pointers and frame queue are cleared, and any in-progress frame on either side is discarded without being counted.
- Write side FSM has two states, W_IDLE and W_FRAME.
  - W_IDLE: in_vld&in_sop starts a frame. The frame start pointer is recorded and the word is written. A same-cycle in_eop marks a 1-word frame: it is dropped, frames_drop+1, and the FSM stays in W_IDLE.
  - W_IDLE: in_vld&!in_sop words are ignored, not counted.
  - W_FRAME: in_vld writes words. in_vld&in_eop commits the frame: its start pointer and length are pushed to the frame queue, and the FSM returns to W_IDLE.
  - W_FRAME: in_vld&in_sop aborts the current frame. The write pointer rewinds to the frame start, frames_drop+1, and the new frame starts in the same cycle.
  - in_vld=0 inside a frame inserts a gap; it is neither an error nor a timeout.
- Overflow: a word arriving when the buffer is full, or an EOP arriving when the frame queue holds MAX_FRAMES, drops the frame.
  - The write pointer rewinds to the frame start and frames_drop+1.
  - The remaining words up to EOP are discarded, and the FSM returns to W_IDLE on EOP.
  - Committed frames are never corrupted.
- Minimum frame length is 2 words; shorter frames are dropped as above.
- Read side FSM has two states, R_IDLE and R_FRAME.
  - out_vld rises on the cycle after the commit edge at the earliest, i.e. 1-cycle commit-to-visible latency.
  - A word transfers when out_vld&out_rdy. out_data/out_sop/out_eop hold stable while out_vld&!out_rdy.
  - Words of one frame are issued back-to-back while out_rdy=1.
  - After an EOP transfer, the next committed frame's first word may be valid the following cycle, giving one word per cycle sustained.
  - On EOP transfer, the frame's words are freed and frames_fwd+1.
- MAC swap, with swap_en latched at the first word:
  - Input layout: word0[63:16]=DA, word0[15:0]=SA[47:32], word1[63:32]=SA[31:0].
  - Output when swapped: word0={SA, DA[47:32]}, word1[63:32]=DA[31:0].
  - word1[31:0] and all later words are unchanged.
  - The swap adds no bubbles.
- Simultaneous events:
  - A write and an EOP-transfer free in the same cycle update buf_level by the net amount.
  - A commit and a queue pop in the same cycle keep the queue count correct.
  - A drop and a forward in the same cycle increment both counters.
- Pointers wrap modulo DEPTH; frames may straddle the wrap point.
- Counters saturate at all-ones.

Test Plan:
1. Single frame, 4 words DA=0x0A0B0C0D0E0F, SA=0x112233445566, swap_en=0, out_rdy=1 -> identical 4 words out, out_sop on word0, out_eop on word3, first out_vld 1 cycle after commit, frames_fwd=1.
2. Same frame with swap_en=1 -> word0[63:0]=0x1122334455660A0B, word1[63:32]=0x0C0D0E0F, remaining bits unchanged.
3. DEPTH=16: send a 10-word frame then a 10-word frame with out_rdy=0 -> first frame committed, second dropped, frames_drop=1, buf_level=10. Release out_rdy -> only the first frame emerges.
4. SOP mid-frame at word 3, then a complete 3-word frame -> frames_drop=1, only the 3-word frame is output.
5. Back-to-back 2-word frames with out_rdy toggling 1010... and pointer wrap exercised over 40 frames -> all frames intact and in order, frames_fwd=40, no data change while stalled.
6. Assert resetN=0 for 1 cycle mid-output -> all outputs 0 next cycle, buf_level=0, counters 0, next frame forwarded normally.
